// File: rtl/main_dec.sv
// Main control decoder for the single-cycle MIPS subset, with registered illegal-opcode status.
// Optional feature: define MAINDEC_BNE_EN to decode BNE (000101) and add the bne output.
module main_dec #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       op,
    output logic             regwrite,
    output logic             regdst,
    output logic             alusrc,
    output logic             branch,
    output logic             memwrite,
    output logic             memtoreg,
    output logic             jump,
    output logic [1:0]       aluop,
`ifdef MAINDEC_BNE_EN
    output logic             bne,
`endif
    output logic             illegal,
    output logic             illegal_seen,
    output logic [5:0]       illegal_op_q,
    output logic [CNT_W-1:0] illegal_cnt
);

    // X/Z opcodes match no item and fall into the illegal default.
    always_comb begin
        regwrite = 1'b0;
        regdst   = 1'b0;
        alusrc   = 1'b0;
        branch   = 1'b0;
        memwrite = 1'b0;
        memtoreg = 1'b0;
        jump     = 1'b0;
        aluop    = 2'b00;
        illegal  = 1'b0;
`ifdef MAINDEC_BNE_EN
        bne      = 1'b0;
`endif
        case (op)
            6'b000000: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
                aluop    = 2'b10;
            end
            6'b100011: begin
                regwrite = 1'b1;
                alusrc   = 1'b1;
                memtoreg = 1'b1;
            end
            6'b101011: begin
                alusrc   = 1'b1;
                memwrite = 1'b1;
            end
            6'b000100: begin
                branch   = 1'b1;
                aluop    = 2'b01;
            end
            6'b001000: begin
                regwrite = 1'b1;
                alusrc   = 1'b1;
            end
            6'b000010: begin
                jump     = 1'b1;
            end
`ifdef MAINDEC_BNE_EN
            6'b000101: begin
                aluop    = 2'b01;
                bne      = 1'b1;
            end
`endif
            default: begin
                illegal  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_seen <= 1'b0;
            illegal_op_q <= '0;
            illegal_cnt  <= '0;
        end else if (illegal) begin
            illegal_seen <= 1'b1;
            illegal_op_q <= op;
            if (illegal_cnt != '1) begin
                illegal_cnt <= illegal_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_main_dec.sv
// Self-checking bench for main_dec: behavioural decode/status model plus directed and random stimulus.
module tb_main_dec;

    localparam int unsigned CNT_W   = 8;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic [5:0]       op;
    logic             regwrite, regdst, alusrc, branch, memwrite, memtoreg, jump;
    logic [1:0]       aluop;
    logic             illegal, illegal_seen;
    logic [5:0]       illegal_op_q;
    logic [CNT_W-1:0] illegal_cnt;
`ifdef MAINDEC_BNE_EN
    logic             bne;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    main_dec #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .op           (op),
        .regwrite     (regwrite),
        .regdst       (regdst),
        .alusrc       (alusrc),
        .branch       (branch),
        .memwrite     (memwrite),
        .memtoreg     (memtoreg),
        .jump         (jump),
        .aluop        (aluop),
`ifdef MAINDEC_BNE_EN
        .bne          (bne),
`endif
        .illegal      (illegal),
        .illegal_seen (illegal_seen),
        .illegal_op_q (illegal_op_q),
        .illegal_cnt  (illegal_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: control strobes derived from what each instruction does.
    function automatic logic [8:0] model_ctl(input logic [5:0] o);
        logic is_r, is_lw, is_sw, is_beq, is_addi, is_j, is_bne;
        logic [1:0] aop;
        is_r    = (o == 6'd0);
        is_lw   = (o == 6'd35);
        is_sw   = (o == 6'd43);
        is_beq  = (o == 6'd4);
        is_addi = (o == 6'd8);
        is_j    = (o == 6'd2);
`ifdef MAINDEC_BNE_EN
        is_bne  = (o == 6'd5);
`else
        is_bne  = 1'b0;
`endif
        aop = is_r ? 2'd2 : ((is_beq || is_bne) ? 2'd1 : 2'd0);
        return {is_r || is_lw || is_addi, is_r, is_lw || is_sw || is_addi,
                is_beq, is_sw, is_lw, is_j, aop};
    endfunction

    function automatic logic model_illegal(input logic [5:0] o);
        logic ok;
        ok = (o == 6'd0) || (o == 6'd35) || (o == 6'd43) || (o == 6'd4) || (o == 6'd8) || (o == 6'd2);
`ifdef MAINDEC_BNE_EN
        ok = ok || (o == 6'd5);
`endif
        return !ok;
    endfunction

    logic       exp_seen = 1'b0;
    logic [5:0] exp_opq  = '0;
    int         exp_cnt  = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_seen = 1'b0;
            exp_opq  = '0;
            exp_cnt  = 0;
        end else if (model_illegal(op)) begin
            exp_seen = 1'b1;
            exp_opq  = op;
            if (exp_cnt < CNT_MAX) exp_cnt = exp_cnt + 1;
        end
    end

    function automatic logic [8:0] dut_ctl();
        return {regwrite, regdst, alusrc, branch, memwrite, memtoreg, jump, aluop};
    endfunction

    always @(negedge clk) begin
        check("ctl", {23'd0, dut_ctl()}, {23'd0, model_ctl(op)});
        check("illegal", {31'd0, illegal}, {31'd0, model_illegal(op)});
`ifdef MAINDEC_BNE_EN
        check("bne", {31'd0, bne}, {31'd0, op == 6'd5});
`endif
        check("seen", {31'd0, illegal_seen}, {31'd0, exp_seen});
        check("op_q", {26'd0, illegal_op_q}, {26'd0, exp_opq});
        check("cnt", {{(32-CNT_W){1'b0}}, illegal_cnt}, exp_cnt);
    end

    task automatic step(input logic [5:0] o);
        op = o;
        @(posedge clk);
        #1;
    endtask

    logic [5:0] tbl_op  [6] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
    logic [8:0] tbl_ctl [6] = '{9'b110000010, 9'b101001000, 9'b001010000,
                                9'b000100001, 9'b101000000, 9'b000000100};

    initial begin
        rst_n = 1'b0;
        op    = 6'b000000;
        repeat (2) @(posedge clk);
        #1;
        check("rst_seen", {31'd0, illegal_seen}, 32'd0);
        check("rst_opq", {26'd0, illegal_op_q}, 32'd0);
        check("rst_cnt", {{(32-CNT_W){1'b0}}, illegal_cnt}, 32'd0);
        #2 rst_n = 1'b1;

        // decode table rows, checked combinationally before the next edge
        for (int i = 0; i < 6; i++) begin
            op = tbl_op[i];
            #1;
            check("tbl_ctl", {23'd0, dut_ctl()}, {23'd0, tbl_ctl[i]});
            check("tbl_illegal", {31'd0, illegal}, 32'd0);
            @(posedge clk);
            #1;
        end
        check("legal_keeps_seen", {31'd0, illegal_seen}, 32'd0);

        op = 6'b111111;
        #1;
        check("ill_ctl", {23'd0, dut_ctl()}, 32'd0);
        check("ill_flag", {31'd0, illegal}, 32'd1);
        @(posedge clk);
        #1;
        check("ill_seen", {31'd0, illegal_seen}, 32'd1);
        check("ill_opq", {26'd0, illegal_op_q}, 32'h3f);
        check("ill_cnt", {{(32-CNT_W){1'b0}}, illegal_cnt}, 32'd1);

        op = 6'b000101;
        #1;
`ifdef MAINDEC_BNE_EN
        check("bne_flag", {31'd0, bne}, 32'd1);
        check("bne_aluop", {30'd0, aluop}, 32'd1);
        check("bne_illegal", {31'd0, illegal}, 32'd0);
`else
        check("op5_illegal", {31'd0, illegal}, 32'd1);
        check("op5_ctl", {23'd0, dut_ctl()}, 32'd0);
`endif
        @(posedge clk);
        #1;

        for (int i = 0; i < 300; i++) step(6'b111110);
        check("sat_cnt", {{(32-CNT_W){1'b0}}, illegal_cnt}, 32'd255);
        step(6'b000000);
        check("sat_hold_cnt", {{(32-CNT_W){1'b0}}, illegal_cnt}, 32'd255);
        check("sat_hold_opq", {26'd0, illegal_op_q}, 32'h3e);

        // asynchronous reset between edges
        op    = 6'b100011;
        rst_n = 1'b0;
        #1;
        check("async_seen", {31'd0, illegal_seen}, 32'd0);
        check("async_opq", {26'd0, illegal_op_q}, 32'd0);
        check("async_cnt", {{(32-CNT_W){1'b0}}, illegal_cnt}, 32'd0);
        check("rst_lw_ctl", {23'd0, dut_ctl()}, 32'b101001000);
        op = 6'b111101;
        repeat (2) @(posedge clk);
        #1;
        check("held_rst_seen", {31'd0, illegal_seen}, 32'd0);
        #2 rst_n = 1'b1;

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(1, 0) == 1)
                step(tbl_op[$urandom_range(5, 0)]);
            else
                step(6'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
